// File: rtl/adder32_err_monitor.sv
// Error monitor for an approximate 32-bit adder: recomputes the exact sum of each
// accepted (a, b) pair and accumulates error metrics over a window of WINDOW samples.
module adder32_err_monitor #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WINDOW     = 1000,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH  = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH:0]   r,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  sample_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [DATA_WIDTH:0]   max_ed,
  output logic [ACC_WIDTH-1:0]  sum_ed
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                state_q;
  logic                  in_ready_q, busy_q, done_q;

  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_b_q;
  logic [DATA_WIDTH:0]   s1_r_q;
  logic                  s2_valid_q;
  logic [DATA_WIDTH:0]   ed_q;

  logic [CNT_WIDTH-1:0]  sample_count_q, err_count_q;
  logic [DATA_WIDTH:0]   max_ed_q;
  logic [ACC_WIDTH-1:0]  sum_ed_q;

  logic                  accept, last_accept, clear;
  logic [DATA_WIDTH:0]   exact, ed_d;
  logic [ACC_WIDTH:0]    sum_wide;
  logic [ACC_WIDTH-1:0]  sum_sat;

  assign accept      = in_valid & in_ready_q;
  assign last_accept = accept && (sample_count_q == CNT_WIDTH'(WINDOW - 1));
  // A start is only honoured from IDLE or DONE; the pipeline is empty there.
  assign clear       = start && ((state_q == StIdle) || (state_q == StDone));

  // Exact sum and absolute error distance of the sample held in stage 1.
  always_comb begin
    exact = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    ed_d  = (s1_r_q >= exact) ? (s1_r_q - exact) : (exact - s1_r_q);
  end

  // Saturating accumulate: one extra bit catches the overflow.
  always_comb begin
    sum_wide = {1'b0, sum_ed_q} + {{(ACC_WIDTH - DATA_WIDTH){1'b0}}, ed_q};
    sum_sat  = sum_wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
  end

  // Window control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StRun;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StRun: begin
          if (last_accept) begin
            state_q    <= StDrain;
            in_ready_q <= 1'b0;
          end
        end
        StDrain: begin
          // Stage 1 empty means the last sample is in stage 2 and lands this edge.
          if (!s1_valid_q) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Two-stage sample pipeline: capture operands, then error distance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_r_q     <= '0;
      s2_valid_q <= 1'b0;
      ed_q       <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q <= a;
        s1_b_q <= b;
        s1_r_q <= r;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        ed_q <= ed_d;
      end
    end
  end

  // Metric accumulation; cleared on an honoured start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_count_q <= '0;
      err_count_q    <= '0;
      max_ed_q       <= '0;
      sum_ed_q       <= '0;
    end else if (clear) begin
      sample_count_q <= '0;
      err_count_q    <= '0;
      max_ed_q       <= '0;
      sum_ed_q       <= '0;
    end else begin
      if (accept) begin
        sample_count_q <= sample_count_q + CNT_WIDTH'(1);
      end
      if (s2_valid_q) begin
        if (ed_q != '0) begin
          err_count_q <= err_count_q + CNT_WIDTH'(1);
        end
        if (ed_q > max_ed_q) begin
          max_ed_q <= ed_q;
        end
        sum_ed_q <= sum_sat;
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_count = sample_count_q;
  assign err_count    = err_count_q;
  assign max_ed       = max_ed_q;
  assign sum_ed       = sum_ed_q;

endmodule

// File: tb/tb_adder32_err_monitor.sv
// Directed bench for adder32_err_monitor: four instances cover the default window,
// small windows for error/carry/handshake cases, and a narrow saturating accumulator.
module tb_adder32_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  start_v;
  logic        in_valid;
  logic [31:0] a, b;
  logic [32:0] r;

  logic [3:0]  ready, busy, done;
  logic [15:0] scnt [4];
  logic [15:0] ecnt [4];
  logic [32:0] mx   [4];
  logic [47:0] sm0, sm1, sm2;
  logic [33:0] sm3;

  int          sel;
  logic        cur_ready, cur_busy, cur_done;
  logic [63:0] cur_scnt, cur_ecnt, cur_mx, cur_sum;

  int          tests = 0;
  int          fails = 0;
  logic [32:0] edq [$];

  always #5 clk = ~clk;

  adder32_err_monitor u_big (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(in_valid), .in_ready(ready[0]),
    .a(a), .b(b), .r(r), .busy(busy[0]), .done(done[0]), .sample_count(scnt[0]),
    .err_count(ecnt[0]), .max_ed(mx[0]), .sum_ed(sm0)
  );

  adder32_err_monitor #(.WINDOW(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(in_valid), .in_ready(ready[1]),
    .a(a), .b(b), .r(r), .busy(busy[1]), .done(done[1]), .sample_count(scnt[1]),
    .err_count(ecnt[1]), .max_ed(mx[1]), .sum_ed(sm1)
  );

  adder32_err_monitor #(.WINDOW(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_valid(in_valid), .in_ready(ready[2]),
    .a(a), .b(b), .r(r), .busy(busy[2]), .done(done[2]), .sample_count(scnt[2]),
    .err_count(ecnt[2]), .max_ed(mx[2]), .sum_ed(sm2)
  );

  adder32_err_monitor #(.WINDOW(3), .ACC_WIDTH(34)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .in_valid(in_valid), .in_ready(ready[3]),
    .a(a), .b(b), .r(r), .busy(busy[3]), .done(done[3]), .sample_count(scnt[3]),
    .err_count(ecnt[3]), .max_ed(mx[3]), .sum_ed(sm3)
  );

  // Route the instance under test to a common set of observation signals.
  always_comb begin
    cur_ready = ready[sel];
    cur_busy  = busy[sel];
    cur_done  = done[sel];
    cur_scnt  = {48'b0, scnt[sel]};
    cur_ecnt  = {48'b0, ecnt[sel]};
    cur_mx    = {31'b0, mx[sel]};
    case (sel)
      0:       cur_sum = {16'b0, sm0};
      1:       cur_sum = {16'b0, sm1};
      2:       cur_sum = {16'b0, sm2};
      default: cur_sum = {30'b0, sm3};
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int s);
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
  endtask

  // Present one sample, wait (bounded) for in_ready, and record its expected distance.
  task automatic push(input logic [31:0] aa, input logic [31:0] bb, input logic [32:0] rr);
    int n = 0;
    logic [32:0] ex;
    a = aa; b = bb; r = rr; in_valid = 1'b1;
    while (!cur_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cur_ready) begin
      chk("push_ready", {63'b0, cur_ready}, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    ex = {1'b0, aa} + {1'b0, bb};
    edq.push_back((rr >= ex) ? (rr - ex) : (ex - rr));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // done must appear exactly two cycles after the last accept and last one cycle.
  task automatic wait_done(input string tag);
    int n = 0;
    while (!cur_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_latency"}, 64'(n), 64'd2);
    chk({tag, "_busy_at_done"}, {63'b0, cur_busy}, 64'd0);
  endtask

  // Pop the scoreboard and compare the reference metrics with the DUT.
  task automatic check_window(input string tag, input logic [63:0] exp_n,
                              input logic [63:0] acc_max);
    logic [63:0] e_err = 0, e_max = 0, e_sum = 0, e;
    while (edq.size() > 0) begin
      e = {31'b0, edq.pop_front()};
      if (e != 0) e_err++;
      if (e > e_max) e_max = e;
      e_sum = e_sum + e;
      if (e_sum > acc_max) e_sum = acc_max;
    end
    chk({tag, "_sample_count"}, cur_scnt, exp_n);
    chk({tag, "_err_count"}, cur_ecnt, e_err);
    chk({tag, "_max_ed"}, cur_mx, e_max);
    chk({tag, "_sum_ed"}, cur_sum, e_sum);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {63'b0, cur_done}, 64'd0);
    chk({tag, "_held"}, cur_scnt, exp_n);
  endtask

  localparam logic [63:0] Acc48 = 64'hFFFF_FFFF_FFFF;
  localparam logic [63:0] Acc34 = 64'h3_FFFF_FFFF;

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0; start_v = '0; in_valid = 1'b0; a = '0; b = '0; r = '0; sel = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", {63'b0, cur_ready}, 64'd0);
    chk("reset_busy", {63'b0, cur_busy}, 64'd0);
    chk("reset_done", {63'b0, cur_done}, 64'd0);
    chk("reset_scnt", cur_scnt, 64'd0);
    chk("reset_sum", cur_sum, 64'd0);

    // Exact sums over a full default window.
    pulse_start(0);
    chk("run_ready", {63'b0, cur_ready}, 64'd1);
    chk("run_busy", {63'b0, cur_busy}, 64'd1);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom(); rb = $urandom();
      push(ra, rb, {1'b0, ra} + {1'b0, rb});
    end
    chk("exact_drain_ready", {63'b0, cur_ready}, 64'd0);
    wait_done("exact");
    chk("exact_err_lit", cur_ecnt, 64'd0);
    check_window("exact", 64'd1000, Acc48);

    // Off-by-one errors in a 4-sample window.
    sel = 1;
    pulse_start(1);
    push(32'd1, 32'd2, 33'd4);
    push(32'd5, 32'd5, 33'd10);
    push(32'd7, 32'd0, 33'd6);
    push(32'd0, 32'd0, 33'd0);
    wait_done("obo");
    chk("obo_err_lit", cur_ecnt, 64'd2);
    chk("obo_sum_lit", cur_sum, 64'd2);
    check_window("obo", 64'd4, Acc48);

    // Carry-out boundary, restarted from DONE.
    pulse_start(1);
    chk("restart_cleared", cur_scnt, 64'd0);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'd0);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE);
    push(32'd0, 32'd0, 33'd0);
    push(32'd1, 32'd1, 33'd2);
    wait_done("carry");
    chk("carry_max_lit", cur_mx, 64'h1_FFFF_FFFE);
    chk("carry_err_lit", cur_ecnt, 64'd1);
    check_window("carry", 64'd4, Acc48);

    // Handshake: valid pattern 1,0,0,1 with a stray start during RUN.
    sel = 2;
    pulse_start(2);
    push(32'd3, 32'd4, 33'd7);
    pulse_start(2);
    chk("hs_gap_scnt", cur_scnt, 64'd1);
    chk("hs_gap_ready", {63'b0, cur_ready}, 64'd1);
    @(negedge clk);
    push(32'd9, 32'd9, 33'd17);
    chk("hs_ready_drop", {63'b0, cur_ready}, 64'd0);
    chk("hs_busy_drain", {63'b0, cur_busy}, 64'd1);
    chk("hs_scnt", cur_scnt, 64'd2);
    wait_done("hs");
    check_window("hs", 64'd2, Acc48);

    // Saturation with a 34-bit accumulator.
    sel = 3;
    pulse_start(3);
    for (int i = 0; i < 3; i++) push(32'd0, 32'd0, 33'h1_FFFF_FFFF);
    wait_done("sat");
    chk("sat_sum_lit", cur_sum, Acc34);
    check_window("sat", 64'd3, Acc34);
    repeat (4) @(negedge clk);
    chk("sat_sum_held", cur_sum, Acc34);

    // Asynchronous reset mid-window, then a fresh full window.
    sel = 0;
    pulse_start(0);
    for (int i = 0; i < 500; i++) begin
      ra = $urandom(); rb = $urandom();
      push(ra, rb, {1'b0, ra} + {1'b0, rb} + 33'(i % 3));
    end
    chk("pre_reset_scnt", cur_scnt, 64'd500);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {63'b0, cur_ready}, 64'd0);
    chk("mid_rst_busy", {63'b0, cur_busy}, 64'd0);
    chk("mid_rst_scnt", cur_scnt, 64'd0);
    chk("mid_rst_ecnt", cur_ecnt, 64'd0);
    chk("mid_rst_max", cur_mx, 64'd0);
    chk("mid_rst_sum", cur_sum, 64'd0);
    edq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", {63'b0, cur_ready}, 64'd0);
    chk("idle_scnt", cur_scnt, 64'd0);
    in_valid = 1'b0;
    pulse_start(0);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom(); rb = $urandom();
      push(ra, rb, {1'b0, ra} + {1'b0, rb} - 33'(i % 2));
    end
    wait_done("rerun");
    check_window("rerun", 64'd1000, Acc48);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder32_err_monitor.md
Name: adder32_err_monitor

Overview:
- Downstream consumer of the 32-bit adder under evaluation.
- Takes each operand pair (a, b) and the adder's 33-bit result r, and recomputes the exact sum internally.
- Accumulates error metrics over a window of WINDOW samples: erroneous-sample count, maximum error distance, and saturating sum of error distances.
- Replaces text-dump comparison with an on-chip quality measurement for approximate adder variants.

Parameters:
- DATA_WIDTH, 32, operand width; result and error distance are DATA_WIDTH+1 bits.
- WINDOW, 1000, samples per measurement window; must be >= 1.
- CNT_WIDTH, 16, width of sample and error counters; must satisfy 2^CNT_WIDTH > WINDOW.
- ACC_WIDTH, 48, width of the error-distance accumulator; saturates, never wraps.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a window when in IDLE or DONE
- in_valid  in  1  sample valid
- in_ready  out  1  monitor accepts a sample this cycle
- a  in  DATA_WIDTH  operand a
- b  in  DATA_WIDTH  operand b
- r  in  DATA_WIDTH+1  adder result under test
- busy  out  1  high in RUN and DRAIN
- done  out  1  single-cycle pulse on entry to DONE
- sample_count  out  CNT_WIDTH  samples accepted in the current/last window
- err_count  out  CNT_WIDTH  samples with r != a+b
- max_ed  out  DATA_WIDTH+1  maximum |r - (a+b)|
- sum_ed  out  ACC_WIDTH  saturating sum of |r - (a+b)|

Behaviour:
- Reset (async assert, sync-deassert assumed upstream):
  - state=IDLE; all counters and accumulators 0.
  - in_ready=0, busy=0, done=0.
- States and transitions:
  - IDLE: start -> clear all metrics, go to RUN.
  - RUN: in_ready=1. Handshake on in_valid&in_ready. On the WINDOW-th accepted sample -> DRAIN; in_ready drops the following cycle.
  - DRAIN: in_ready=0. Waits until the 2-stage pipeline is empty (exactly 2 cycles after the last accept), then -> DONE.
  - DONE: done=1 for one cycle only. Metrics held stable. start -> clear and go to RUN.
- start in RUN or DRAIN is ignored.
- Accepted sample with in_valid=0 is not possible; in_valid without in_ready is not consumed. Upstream holds data; no internal buffering.
- Pipeline:
  - Stage 1 registers a, b, r and the valid bit.
  - Stage 2 computes exact = a+b (zero-extended, DATA_WIDTH+1 bits), ed = r>=exact ? r-exact : exact-r, and updates metrics.
  - Metrics reflect a sample 2 cycles after its accept edge.
- Metric update rules:
  - sample_count increments at accept.
  - err_count += (ed!=0).
  - max_ed = max(max_ed, ed).
  - sum_ed = min(sum_ed+ed, 2^ACC_WIDTH-1).
- Gaps in in_valid are allowed anytime in RUN; the window counts accepted samples only.
- rst_n low mid-window discards everything immediately (async); the next window requires start.

Test Plan:
- Exact sums: start, 1000 samples with r=a+b from random a,b -> done after last accept+2 cycles; sample_count=1000, err_count=0, max_ed=0, sum_ed=0.
- Off-by-one: WINDOW=4, samples (1,2,r=4),(5,5,r=10),(7,0,r=6),(0,0,r=0) -> err_count=2, max_ed=1, sum_ed=2.
- Carry-out boundary: a=b=0xFFFFFFFF, r=0 -> ed=0x1FFFFFFFE; max_ed=0x1FFFFFFFE, err_count=1. Also r=0x1FFFFFFFE -> no error.
- Handshake: in_valid toggled 1,0,0,1 with WINDOW=2 -> exactly 2 accepts; in_ready=0 from the cycle after the 2nd accept; start during RUN ignored; done pulses once.
- Saturation: ACC_WIDTH=34, WINDOW=3, three samples with ed=0x1FFFFFFFF each -> sum_ed=0x3FFFFFFFF, held.
- Reset mid-window: rst_n low after 500 samples -> all outputs 0, state IDLE, in_ready=0; a new start runs a full 1000-sample window.
